// File: rtl/wb_stage.sv
// wb_stage: writeback pipeline register, register-file write port, retire counter
// and halt latch. Define WB_COMMIT_TRACE_EN to add the back-pressured commit trace port.
module wb_stage #(
   parameter int unsigned          CNT_WIDTH = 64,
   parameter int unsigned          PC_WIDTH  = 64,
   parameter int unsigned          REG_WIDTH = 6,
   parameter int unsigned          CPU_WIDTH = 64,
   parameter logic [REG_WIDTH-1:0] RNONE     = '1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 M_valid_i,
   input  logic [PC_WIDTH-1:0]  M_pc_i,
   input  logic [1:0]           M_stat_i,
   input  logic [REG_WIDTH-1:0] M_dstE_i,
   input  logic [CPU_WIDTH-1:0] M_valE_i,
   input  logic [REG_WIDTH-1:0] M_dstM_i,
   input  logic [CPU_WIDTH-1:0] m_valM_i,
   input  logic                 W_stall_i,
   input  logic                 W_bubble_i,
   output logic [REG_WIDTH-1:0] W_dstE_o,
   output logic [CPU_WIDTH-1:0] W_valE_o,
   output logic [REG_WIDTH-1:0] W_dstM_o,
   output logic [CPU_WIDTH-1:0] W_valM_o,
   output logic                 wb_stall_o,
   output logic                 halted_o,
   output logic [1:0]           stat_o,
   output logic [CNT_WIDTH-1:0] instret_o
`ifdef WB_COMMIT_TRACE_EN
   ,
   output logic                 commit_valid_o,
   input  logic                 commit_ready_i,
   output logic [PC_WIDTH-1:0]  commit_pc_o,
   output logic [REG_WIDTH-1:0] commit_rd_o,
   output logic [CPU_WIDTH-1:0] commit_data_o
`endif
);

   localparam logic [1:0] STAT_AOK = 2'd0;

   typedef struct packed {
      logic                 valid;
      logic [PC_WIDTH-1:0]  pc;
      logic [1:0]           stat;
      logic [REG_WIDTH-1:0] dst_e;
      logic [CPU_WIDTH-1:0] val_e;
      logic [REG_WIDTH-1:0] dst_m;
      logic [CPU_WIDTH-1:0] val_m;
   } w_reg_t;

   typedef enum logic {
      S_RUN,
      S_HALT
   } state_t;

   w_reg_t               w_q, w_d, m_in, w_bubble;
   state_t               state_q, state_d;
   logic [1:0]           stat_q, stat_d;
   logic [CNT_WIDTH-1:0] instret_q;
   logic                 run, hold, retire, wb_stall;

   assign w_bubble = '{valid: 1'b0, pc: '0, stat: STAT_AOK,
                       dst_e: RNONE, val_e: '0, dst_m: RNONE, val_m: '0};

   // A bubble arriving from M must never write the register file.
   always_comb begin
      m_in.valid = M_valid_i;
      m_in.pc    = M_pc_i;
      m_in.stat  = M_stat_i;
      m_in.dst_e = M_valid_i ? M_dstE_i : RNONE;
      m_in.val_e = M_valE_i;
      m_in.dst_m = M_valid_i ? M_dstM_i : RNONE;
      m_in.val_m = m_valM_i;
   end

   // Commit back-pressure outranks the hazard unit's bubble so an uncommitted
   // instruction is never overwritten.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      w_d = w_q;
      if (wb_stall) begin
         w_d = w_q;
      end else if (W_bubble_i) begin
         w_d = w_bubble;
      end else if (W_stall_i) begin
         w_d = w_q;
      end else begin
         w_d = m_in;
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (rst_i) begin
         w_q <= w_bubble;
      end else begin
         w_q <= w_d;
      end
   end

   assign run  = (state_q == S_RUN);
   assign hold = W_stall_i | wb_stall;

   always_comb begin
      state_d = state_q;
      stat_d  = stat_q;
      if (run && w_q.valid && (w_q.stat != STAT_AOK) && !hold) begin
         state_d = S_HALT;
         stat_d  = w_q.stat;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_RUN;
         stat_q  <= STAT_AOK;
      end else begin
         state_q <= state_d;
         stat_q  <= stat_d;
      end
   end

   // HLT retires; ADR/INS (stat[1] set) are faults and do not.
   assign retire = w_q.valid & run & ~hold & ~w_q.stat[1];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         instret_q <= '0;
      end else if (retire) begin
         instret_q <= instret_q + CNT_WIDTH'(1);
      end
   end

   assign W_dstE_o   = run ? w_q.dst_e : RNONE;
   assign W_valE_o   = w_q.val_e;
   assign W_dstM_o   = run ? w_q.dst_m : RNONE;
   assign W_valM_o   = w_q.val_m;
   assign wb_stall_o = wb_stall;
   assign halted_o   = (state_q == S_HALT);
   assign stat_o     = stat_q;
   assign instret_o  = instret_q;

`ifdef WB_COMMIT_TRACE_EN
   // Payload comes straight from W, which is frozen while the stall holds.
   assign commit_valid_o = w_q.valid & run;
   assign commit_pc_o    = w_q.pc;
   assign commit_rd_o    = (w_q.dst_m != RNONE) ? w_q.dst_m : w_q.dst_e;
   assign commit_data_o  = (w_q.dst_m != RNONE) ? w_q.val_m : w_q.val_e;
   assign wb_stall       = commit_valid_o & ~commit_ready_i;
`else
   logic unused_pc;
   assign unused_pc = ^w_q.pc;
   assign wb_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed scoreboard bench for wb_stage (8-bit counter so wrap is reachable).
// Commit-port steps run only when WB_COMMIT_TRACE_EN is defined.
module tb_wb_stage;

   localparam int unsigned   CW    = 8;
   localparam logic [5:0]    RNONE = 6'h3f;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        M_valid_i;
   logic [63:0] M_pc_i;
   logic [1:0]  M_stat_i;
   logic [5:0]  M_dstE_i, M_dstM_i;
   logic [63:0] M_valE_i, m_valM_i;
   logic        W_stall_i, W_bubble_i;
   logic [5:0]  W_dstE_o, W_dstM_o;
   logic [63:0] W_valE_o, W_valM_o;
   logic        wb_stall_o, halted_o;
   logic [1:0]  stat_o;
   logic [CW-1:0] instret_o;
`ifdef WB_COMMIT_TRACE_EN
   logic        commit_valid_o, commit_ready_i;
   logic [63:0] commit_pc_o, commit_data_o;
   logic [5:0]  commit_rd_o;
   int          hs_count = 0;
   int          hs_base;
`endif

   int checks = 0;
   int errors = 0;
   int exp_ins = 0;
   logic [63:0] pc_ctr = 64'h1000;

   typedef struct {
      logic [5:0]  dst_e;
      logic [63:0] val_e;
      logic [5:0]  dst_m;
      logic [63:0] val_m;
   } wr_t;
   wr_t sb_q[$];

   wb_stage #(.CNT_WIDTH(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .M_valid_i(M_valid_i), .M_pc_i(M_pc_i), .M_stat_i(M_stat_i),
      .M_dstE_i(M_dstE_i), .M_valE_i(M_valE_i), .M_dstM_i(M_dstM_i), .m_valM_i(m_valM_i),
      .W_stall_i(W_stall_i), .W_bubble_i(W_bubble_i),
      .W_dstE_o(W_dstE_o), .W_valE_o(W_valE_o), .W_dstM_o(W_dstM_o), .W_valM_o(W_valM_o),
      .wb_stall_o(wb_stall_o), .halted_o(halted_o), .stat_o(stat_o), .instret_o(instret_o)
`ifdef WB_COMMIT_TRACE_EN
      ,
      .commit_valid_o(commit_valid_o), .commit_ready_i(commit_ready_i),
      .commit_pc_o(commit_pc_o), .commit_rd_o(commit_rd_o), .commit_data_o(commit_data_o)
`endif
   );

   always #5 clk_i = ~clk_i;

`ifdef WB_COMMIT_TRACE_EN
   always @(posedge clk_i) begin
      if (commit_valid_o && commit_ready_i) hs_count <= hs_count + 1;
   end
`endif

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_m(input logic v, input logic [1:0] st, input logic [5:0] de,
                          input logic [63:0] ve, input logic [5:0] dm, input logic [63:0] vm);
      M_valid_i = v;
      M_pc_i    = pc_ctr;
      M_stat_i  = st;
      M_dstE_i  = de;
      M_valE_i  = ve;
      M_dstM_i  = dm;
      m_valM_i  = vm;
      pc_ctr    = pc_ctr + 64'd4;
   endtask

   task automatic push(input logic [5:0] de, input logic [63:0] ve, input logic [5:0] dm,
                       input logic [63:0] vm);
      wr_t e;
      e.dst_e = de; e.val_e = ve; e.dst_m = dm; e.val_m = vm;
      sb_q.push_back(e);
   endtask

   task automatic alu(input logic [5:0] rd, input logic [63:0] val);
      drive_m(1'b1, 2'd0, rd, val, RNONE, 64'd0);
      push(rd, val, RNONE, 64'd0);
   endtask

   task automatic idle();
      drive_m(1'b0, 2'd0, 6'd0, 64'd0, 6'd0, 64'd0);
      push(RNONE, 64'd0, RNONE, 64'd0);
   endtask

   task automatic expect_w(input string tag);
      wr_t e;
      e = sb_q.pop_front();
      check({tag, "_dstE"}, W_dstE_o, e.dst_e);
      check({tag, "_valE"}, W_valE_o, e.val_e);
      check({tag, "_dstM"}, W_dstM_o, e.dst_m);
      check({tag, "_valM"}, W_valM_o, e.val_m);
   endtask

   task automatic check_ins(input string tag);
      check(tag, instret_o, 64'(exp_ins % 256));
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_dstE"}, W_dstE_o, RNONE);
      check({tag, "_dstM"}, W_dstM_o, RNONE);
      check({tag, "_halted"}, halted_o, 1'b0);
      check({tag, "_stat"}, stat_o, 2'd0);
      check({tag, "_instret"}, instret_o, 0);
      check({tag, "_wbstall"}, wb_stall_o, 1'b0);
`ifdef WB_COMMIT_TRACE_EN
      check({tag, "_cvalid"}, commit_valid_o, 1'b0);
`endif
   endtask

   initial begin
      rst_i = 1'b1;
      W_stall_i = 1'b0;
      W_bubble_i = 1'b0;
`ifdef WB_COMMIT_TRACE_EN
      commit_ready_i = 1'b1;
`endif
      drive_m(1'b0, 2'd0, 6'd0, 64'd0, 6'd0, 64'd0);
      tick();
      tick();
      check_reset("rst");
      rst_i = 1'b0;

      // back-to-back ALU ops, one-cycle M->W latency
      alu(6'd5, 64'd7);  tick(); expect_w("alu_x5");
      alu(6'd6, 64'd9);  tick(); expect_w("alu_x6"); exp_ins = 1;
      alu(6'd7, 64'd16); tick(); expect_w("alu_x7"); exp_ins = 2; check_ins("alu_ins_mid");
      idle();            tick(); expect_w("alu_drain"); exp_ins = 3; check_ins("alu_ins");

      // load held by W_stall for two cycles
      drive_m(1'b1, 2'd0, RNONE, 64'h100, 6'd8, 64'h55);
      push(RNONE, 64'h100, 6'd8, 64'h55);
      tick(); expect_w("ld_load");
      W_stall_i = 1'b1;
      drive_m(1'b1, 2'd0, 6'd11, 64'hbb, RNONE, 64'd0);
      tick(); check("ld_hold1_dstM", W_dstM_o, 6'd8); check("ld_hold1_valM", W_valM_o, 64'h55);
      check_ins("ld_hold1_ins");
      tick(); check("ld_hold2_dstM", W_dstM_o, 6'd8); check_ins("ld_hold2_ins");
      W_stall_i = 1'b0;
      idle(); tick(); expect_w("ld_release"); exp_ins++; check_ins("ld_ins");

      // bubble pulse mid-stream
      alu(6'd12, 64'd1); tick(); expect_w("bub_pre");
      drive_m(1'b1, 2'd0, 6'd13, 64'd2, RNONE, 64'd0);
      W_bubble_i = 1'b1;
      push(RNONE, 64'd0, RNONE, 64'd0);
      tick(); expect_w("bub_cycle"); exp_ins++; check_ins("bub_ins");
      W_bubble_i = 1'b0;
      alu(6'd14, 64'd3); tick(); expect_w("bub_post"); check_ins("bub_no_retire");
      idle(); tick(); expect_w("bub_drain"); exp_ins++; check_ins("bub_drain_ins");

`ifdef WB_COMMIT_TRACE_EN
      // commit back-pressure for four cycles with a concurrent bubble request
      drive_m(1'b1, 2'd0, 6'd9, 64'h1234, RNONE, 64'd0);
      push(6'd9, 64'h1234, RNONE, 64'd0);
      tick(); expect_w("tr_load"); check("tr_cvalid", commit_valid_o, 1'b1);
      hs_base = hs_count;
      commit_ready_i = 1'b0;
      W_bubble_i = 1'b1;
      drive_m(1'b1, 2'd0, 6'd15, 64'hff, RNONE, 64'd0);
      #1;
      for (int i = 0; i < 4; i++) begin
         check("tr_wbstall", wb_stall_o, 1'b1);
         check("tr_rd", commit_rd_o, 6'd9);
         check("tr_data", commit_data_o, 64'h1234);
         check("tr_dstE", W_dstE_o, 6'd9);
         check_ins("tr_stall_ins");
         tick();
      end
      commit_ready_i = 1'b1;
      W_bubble_i = 1'b0;
      idle();
      #1;
      check("tr_release", wb_stall_o, 1'b0);
      tick(); expect_w("tr_drain"); exp_ins++; check_ins("tr_ins");
      check("tr_handshakes", hs_count - hs_base, 1);
`endif

      // ebreak followed by a write to x10 that must be suppressed
      drive_m(1'b1, 2'd1, RNONE, 64'd0, RNONE, 64'd0);
      tick(); check("hlt_not_yet", halted_o, 1'b0);
      drive_m(1'b1, 2'd0, 6'd10, 64'haa, RNONE, 64'd0);
      tick(); exp_ins++;
      check("hlt_halted", halted_o, 1'b1);
      check("hlt_stat", stat_o, 2'd1);
      check_ins("hlt_ins");
      check("hlt_x10_dstE", W_dstE_o, RNONE);
      check("hlt_x10_dstM", W_dstM_o, RNONE);
      drive_m(1'b1, 2'd0, 6'd10, 64'haa, RNONE, 64'd0);
      tick();
      check("hlt_stay", halted_o, 1'b1);
      check("hlt_x10_again", W_dstE_o, RNONE);
      check_ins("hlt_ins_frozen");
      rst_i = 1'b1;
      tick(); check_reset("hlt_rst");
      rst_i = 1'b0; exp_ins = 0;

`ifdef WB_COMMIT_TRACE_EN
      // reset while the commit port is stalling discards the pending commit
      drive_m(1'b1, 2'd0, 6'd9, 64'h77, RNONE, 64'd0);
      tick();
      commit_ready_i = 1'b0;
      rst_i = 1'b1;
      tick(); check_reset("stall_rst");
      commit_ready_i = 1'b1;
      rst_i = 1'b0;
`endif

      // faulting instruction halts without retiring
      drive_m(1'b1, 2'd2, 6'd3, 64'h77, RNONE, 64'd0);
      tick(); check("flt_dstE", W_dstE_o, 6'd3);
      drive_m(1'b0, 2'd0, 6'd0, 64'd0, 6'd0, 64'd0);
      tick();
      check("flt_halted", halted_o, 1'b1);
      check("flt_stat", stat_o, 2'd2);
      check_ins("flt_ins");
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;

      // counter wrap: 255 retires to all-ones, one more to zero
      for (int i = 0; i < 255; i++) begin
         drive_m(1'b1, 2'd0, 6'd1, 64'(i), RNONE, 64'd0);
         tick();
      end
      drive_m(1'b0, 2'd0, 6'd0, 64'd0, 6'd0, 64'd0);
      tick(); check("wrap_ones", instret_o, 8'hff);
      drive_m(1'b1, 2'd0, 6'd1, 64'd1, RNONE, 64'd0);
      tick();
      drive_m(1'b0, 2'd0, 6'd0, 64'd0, 6'd0, 64'd0);
      tick(); check("wrap_zero", instret_o, 8'h00);

      check("sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
